// File: rtl/mc10_kbd_matrix_if.sv
// mc10_kbd_matrix_if: ps2_key event input and CPU column/row keyboard read path
interface mc10_kbd_matrix_if;
    logic [10:0] ps2_key;
    logic [7:0]  col_n;
    logic [6:0]  rows_n;
    logic        any_down;
    modport master (output ps2_key, col_n, input rows_n, any_down);
    modport slave  (input ps2_key, col_n, output rows_n, any_down);
endinterface

// File: rtl/mc10_kbd_matrix.sv
// mc10_kbd_matrix: ps2_key events to MC-10 8x7 key matrix with minimum-hold release queue
module mc10_kbd_matrix #(
    parameter logic [15:0] HOLD_CYC = 16'd50000,
    parameter int          RQ_DEPTH = 4
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    mc10_kbd_matrix_if.slave kb
);
    localparam int AW = $clog2(RQ_DEPTH);
    logic          tgl_q, s1_vld, s1_press, s1_ext;
    logic [7:0]    s1_code;
    logic [55:0]   mtx, mtx_nx;
    logic [15:0]   tmr;
    logic [5:0]    rq [RQ_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   cnt;
    logic          dec_vld;
    logic [5:0]    dec_key;
    logic          press, rel, push, pop, tmr_zero, q_empty, q_full;
    // dec_key is {row,col}, written in octal so each digit reads as row then column
    always_comb begin
        dec_vld = 1'b1;
        dec_key = 6'o00;
        if (s1_ext) begin
            dec_vld = s1_code == 8'h14;
            dec_key = 6'o60;
        end else begin
            case (s1_code)
                8'h52: dec_key = 6'o00;
                8'h1C: dec_key = 6'o01;
                8'h32: dec_key = 6'o02;
                8'h21: dec_key = 6'o03;
                8'h23: dec_key = 6'o04;
                8'h24: dec_key = 6'o05;
                8'h2B: dec_key = 6'o06;
                8'h34: dec_key = 6'o07;
                8'h33: dec_key = 6'o10;
                8'h43: dec_key = 6'o11;
                8'h3B: dec_key = 6'o12;
                8'h42: dec_key = 6'o13;
                8'h4B: dec_key = 6'o14;
                8'h3A: dec_key = 6'o15;
                8'h31: dec_key = 6'o16;
                8'h44: dec_key = 6'o17;
                8'h4D: dec_key = 6'o20;
                8'h15: dec_key = 6'o21;
                8'h2D: dec_key = 6'o22;
                8'h1B: dec_key = 6'o23;
                8'h2C: dec_key = 6'o24;
                8'h3C: dec_key = 6'o25;
                8'h2A: dec_key = 6'o26;
                8'h1D: dec_key = 6'o27;
                8'h22: dec_key = 6'o30;
                8'h35: dec_key = 6'o31;
                8'h1A: dec_key = 6'o32;
                8'h5A: dec_key = 6'o35;
                8'h29: dec_key = 6'o37;
                8'h45: dec_key = 6'o40;
                8'h16: dec_key = 6'o41;
                8'h1E: dec_key = 6'o42;
                8'h26: dec_key = 6'o43;
                8'h25: dec_key = 6'o44;
                8'h2E: dec_key = 6'o45;
                8'h36: dec_key = 6'o46;
                8'h3D: dec_key = 6'o47;
                8'h3E: dec_key = 6'o50;
                8'h46: dec_key = 6'o51;
                8'h54: dec_key = 6'o52;
                8'h4C: dec_key = 6'o53;
                8'h41: dec_key = 6'o54;
                8'h4E: dec_key = 6'o55;
                8'h49: dec_key = 6'o56;
                8'h4A: dec_key = 6'o57;
                8'h14: dec_key = 6'o60;
                8'h76: dec_key = 6'o62;
                8'h12: dec_key = 6'o67;
                8'h59: dec_key = 6'o67;
                default: dec_vld = 1'b0;
            endcase
        end
    end
    assign tmr_zero = tmr == 16'd0;
    assign q_empty  = cnt == '0;
    assign q_full   = cnt == (AW+1)'(RQ_DEPTH);
    assign press    = s1_vld & dec_vld & s1_press;
    assign rel      = s1_vld & dec_vld & ~s1_press;
    assign push     = rel & ~(tmr_zero & q_empty) & ~q_full;
    assign pop      = tmr_zero & ~q_empty & ~press;
    always_comb begin
        mtx_nx = mtx;
        if (pop) mtx_nx[rq[rd_ptr]] = 1'b0;
        if (press) mtx_nx[dec_key] = 1'b1;
        if (rel & ~push) mtx_nx[dec_key] = 1'b0;
    end
    always_ff @(posedge clk_sys) begin
        tgl_q <= kb.ps2_key[10];
        {s1_press, s1_ext, s1_code} <= kb.ps2_key[9:0];
        if (!reset_n) begin
            s1_vld      <= 1'b0;
            mtx         <= '0;
            tmr         <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            cnt         <= '0;
            kb.rows_n   <= 7'h7F;
            kb.any_down <= 1'b0;
        end else begin
            s1_vld <= kb.ps2_key[10] != tgl_q;
            mtx    <= mtx_nx;
            tmr    <= press ? HOLD_CYC : tmr - {15'd0, ~tmr_zero};
            if (push) begin
                rq[wr_ptr] <= dec_key;
                wr_ptr     <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            for (int r = 0; r < 7; r++) kb.rows_n[r] <= ~|(mtx[r*8 +: 8] & ~kb.col_n);
            kb.any_down <= |mtx;
        end
    end
endmodule

// File: tb/tb_mc10_kbd_matrix.sv
// tb_mc10_kbd_matrix: directed and random key events against a timestamp/queue keyboard model
module tb_mc10_kbd_matrix;
    localparam int HOLD  = 100;
    localparam int DEPTH = 4;
    localparam int NEVER = -1000000;
    logic clk_sys = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   failures = 0;
    mc10_kbd_matrix_if kb();
    mc10_kbd_matrix #(.HOLD_CYC(16'(HOLD)), .RQ_DEPTH(DEPTH)) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .kb(kb)
    );
    always #5 clk_sys = ~clk_sys;
    // keyboard layout, index = row*8 + col, 0 = no key at that position
    byte unsigned keymap [56] = '{
        8'h52, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44,
        8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D,
        8'h22, 8'h35, 8'h1A, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h29,
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
        8'h3E, 8'h46, 8'h54, 8'h4C, 8'h41, 8'h4E, 8'h49, 8'h4A,
        8'h14, 8'h00, 8'h76, 8'h00, 8'h00, 8'h00, 8'h00, 8'h12};
    byte unsigned pool [12] = '{8'h1C, 8'h32, 8'h21, 8'h12, 8'h59, 8'h14,
                                8'h76, 8'h5A, 8'h29, 8'h45, 8'h4A, 8'h05};
    logic [55:0] m_down;
    int          q[$];
    int          cyc = 0;
    int          last_press = NEVER;
    logic        m_tgl, p_vld;
    logic [9:0]  p_dat;
    logic [6:0]  e_rows;
    logic        e_any;

    function automatic int ref_key(logic ext, logic [7:0] code);
        if (ext) return (code == 8'h14) ? 48 : -1;
        if (code == 8'h59) return 55;
        for (int i = 0; i < 56; i++) if (keymap[i] != 0 && keymap[i] == code) return i;
        return -1;
    endfunction

    // called right after each rising edge; inputs are stable there
    task automatic model_update();
        int k;
        bit zero, pop_ok, prs;
        cyc++;
        for (int r = 0; r < 7; r++) e_rows[r] = ~|(m_down[r*8 +: 8] & ~kb.col_n);
        e_any = |m_down;
        if (!reset_n) begin
            m_down = '0;
            q.delete();
            last_press = NEVER;
            m_tgl = kb.ps2_key[10];
            p_vld = 1'b0;
            e_rows = 7'h7F;
            e_any = 1'b0;
            return;
        end
        zero = (cyc - 1 - last_press) >= HOLD;
        k = p_vld ? ref_key(p_dat[8], p_dat[7:0]) : -1;
        prs = k >= 0 && p_dat[9];
        pop_ok = zero && q.size() > 0 && !prs;
        if (prs) begin
            m_down[k] = 1'b1;
            last_press = cyc;
        end else if (k >= 0) begin
            if ((zero && q.size() == 0) || q.size() == DEPTH) m_down[k] = 1'b0;
            else q.push_back(k);
        end
        if (pop_ok) m_down[q.pop_front()] = 1'b0;
        p_vld = kb.ps2_key[10] != m_tgl;
        p_dat = kb.ps2_key[9:0];
        m_tgl = kb.ps2_key[10];
    endtask

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        model_update();
        @(negedge clk_sys);
        chk("model_rows_n", {1'b0, kb.rows_n}, {1'b0, e_rows});
        chk("model_any_down", {7'd0, kb.any_down}, {7'd0, e_any});
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic key(logic [7:0] code, logic ext, logic prs);
        kb.ps2_key = {~kb.ps2_key[10], prs, ext, code};
        idle(2);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        chk("reset_rows_n", {1'b0, kb.rows_n}, 8'h7F);
        chk("reset_any_down", {7'd0, kb.any_down}, 8'h00);
    endtask

    initial begin
        int gap;
        reset_n = 1'b0;
        kb.ps2_key = '0;
        kb.col_n = 8'hFF;
        do_reset();
        // A sits at row0 col1: latency to rows_n is three edges after the toggle
        kb.col_n = 8'hFD;
        kb.ps2_key = {~kb.ps2_key[10], 1'b1, 1'b0, 8'h1C};
        idle(2);
        chk("t1_before_latency", {1'b0, kb.rows_n}, 8'h7F);
        step();
        chk("t1_row0_low", {1'b0, kb.rows_n}, 8'h7E);
        chk("t1_any_down", {7'd0, kb.any_down}, 8'h01);
        kb.col_n = 8'hFE;
        step();
        chk("t1_other_col", {1'b0, kb.rows_n}, 8'h7F);
        // fast SHIFT release is deferred until the hold time expires
        do_reset();
        kb.col_n = 8'h7F;
        key(8'h12, 1'b0, 1'b1);
        idle(8);
        key(8'h12, 1'b0, 1'b0);
        idle(80);
        chk("t2_shift_held", {1'b0, kb.rows_n}, 8'h3F);
        idle(15);
        chk("t2_shift_cleared", {1'b0, kb.rows_n}, 8'h7F);
        chk("t2_any_down", {7'd0, kb.any_down}, 8'h00);
        // five releases into a four-entry queue: the last clears immediately
        do_reset();
        key(8'h1C, 1'b0, 1'b1);
        key(8'h32, 1'b0, 1'b1);
        key(8'h21, 1'b0, 1'b1);
        key(8'h23, 1'b0, 1'b1);
        key(8'h24, 1'b0, 1'b1);
        key(8'h1C, 1'b0, 1'b0);
        key(8'h32, 1'b0, 1'b0);
        key(8'h21, 1'b0, 1'b0);
        key(8'h23, 1'b0, 1'b0);
        key(8'h24, 1'b0, 1'b0);
        kb.col_n = 8'hDF;
        step();
        chk("t3_e_immediate", {1'b0, kb.rows_n}, 8'h7F);
        kb.col_n = 8'hE1;
        step();
        chk("t3_a_to_d_held", {1'b0, kb.rows_n}, 8'h7E);
        idle(110);
        chk("t3_all_cleared", {1'b0, kb.rows_n}, 8'h7F);
        chk("t3_any_down", {7'd0, kb.any_down}, 8'h00);
        // both CTRL keys share one bit; a single release clears it
        do_reset();
        kb.col_n = 8'hFE;
        key(8'h14, 1'b1, 1'b1);
        key(8'h14, 1'b0, 1'b1);
        chk("t4_ctrl_down", {1'b0, kb.rows_n}, 8'h3F);
        key(8'h14, 1'b0, 1'b0);
        idle(110);
        chk("t4_ctrl_cleared", {1'b0, kb.rows_n}, 8'h7F);
        chk("t4_any_down", {7'd0, kb.any_down}, 8'h00);
        // unmapped code and a toggle during reset must leave the matrix empty
        do_reset();
        kb.col_n = 8'h00;
        key(8'h05, 1'b0, 1'b1);
        idle(2);
        chk("t5_unmapped_rows", {1'b0, kb.rows_n}, 8'h7F);
        chk("t5_unmapped_any", {7'd0, kb.any_down}, 8'h00);
        reset_n = 1'b0;
        idle(1);
        kb.ps2_key = {~kb.ps2_key[10], 1'b1, 1'b0, 8'h1C};
        idle(2);
        reset_n = 1'b1;
        idle(4);
        chk("t5_reset_toggle", {7'd0, kb.any_down}, 8'h00);
        // random events checked every cycle against the model
        do_reset();
        for (int n = 0; n < 300; n++) begin
            kb.ps2_key = {~kb.ps2_key[10], 1'($urandom), ($urandom_range(0, 7) == 0), pool[$urandom_range(0, 11)]};
            gap = ($urandom_range(0, 9) == 0) ? $urandom_range(100, 140) : $urandom_range(2, 12);
            for (int i = 0; i < gap; i++) begin
                kb.col_n = 8'($urandom);
                step();
            end
        end
        kb.col_n = 8'h00;
        idle(150);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
